// File: rtl/audio_in_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : audio_in_deserializer
// Purpose  : Captures the codec's serial ADC stream, which is in I2S format,
//            into parallel stereo samples. Each sample is sign-extended and
//            written into the left or right input FIFO. The module counts
//            samples that are dropped because the FIFO is full, and it
//            reports when frame alignment is lost.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH        FIFO word width (must be >= AUDIO_DATA_WIDTH)
//   AUDIO_DATA_WIDTH  bits captured per channel per frame (>= 2)
// Ports
//   clk                   in   system clock
//   reset                 in   synchronous active-high reset
//   bit_clk               in   codec BCLK, already synchronised to clk
//   lr_clk                in   codec LRCK, already synchronised (0=left)
//   serial_audio_in_data  in   codec ADCDAT, already synchronised to clk
//   enable                in   capture enable
//   left_fifo_is_full     in   left FIFO full flag
//   right_fifo_is_full    in   right FIFO full flag
//   left_write_en         out  one-cycle write strobe, left FIFO
//   right_write_en        out  one-cycle write strobe, right FIFO
//   write_data            out  sign-extended sample, shared by both FIFOs
//   overflow_count        out  saturating count of dropped samples
//   sync_locked           out  high while frames are captured correctly
// Build option
//   AUDIO_IN_LEFT_JUSTIFIED_EN  define this for left-justified input. In
//                               that mode there is no one-bit delay after
//                               the LRCK edge.
// ============================================================================
module audio_in_deserializer #(
    parameter int DATA_WIDTH       = 32,
    parameter int AUDIO_DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_clk,
    input  logic                  lr_clk,
    input  logic                  serial_audio_in_data,
    input  logic                  enable,
    input  logic                  left_fifo_is_full,
    input  logic                  right_fifo_is_full,
    output logic                  left_write_en,
    output logic                  right_write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [7:0]            overflow_count,
    output logic                  sync_locked
);

    localparam int c_CNT_W = (AUDIO_DATA_WIDTH > 1) ? $clog2(AUDIO_DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(AUDIO_DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] c_ST_SHIFT     = 3'd3;
    localparam logic [2:0] c_ST_HOLD      = 3'd4;
`ifdef AUDIO_IN_LEFT_JUSTIFIED_EN
    // The MSB arrives on the first BCLK rise after the LRCK edge.
    localparam logic [2:0] c_ST_FRAME_FIRST = c_ST_SHIFT;
`else
    // In I2S, the first BCLK rise after the LRCK edge is a dead slot.
    localparam logic [2:0] c_ST_SKIP        = 3'd2;
    localparam logic [2:0] c_ST_FRAME_FIRST = c_ST_SKIP;
`endif

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_next;
    logic                        r_bit_clk_q;
    logic                        r_lr_clk_q;
    logic                        r_channel;
    logic [AUDIO_DATA_WIDTH-2:0] r_shift;
    logic [c_CNT_W-1:0]          r_cnt;
    logic                        r_wr_pulse;
    logic [DATA_WIDTH-1:0]       r_write_data;
    logic [7:0]                  r_overflow_count;
    logic                        r_sync_locked;

    logic                        w_bclk_rise;
    logic                        w_lr_edge;
    logic                        w_start_frame;
    logic                        w_shift_en;
    logic                        w_last_bit;
    logic                        w_frame_err;
    logic [AUDIO_DATA_WIDTH-1:0] w_sample;
    logic [DATA_WIDTH-1:0]       w_sample_ext;
    logic                        w_target_full;
    logic                        w_left_we;
    logic                        w_right_we;
    logic                        w_drop;

    assign w_bclk_rise = bit_clk & ~r_bit_clk_q;
    assign w_lr_edge   = lr_clk ^ r_lr_clk_q;

    // The shift register holds only the bits already received. The bit that
    // arrives in the current cycle is appended here. Because of this, the
    // complete sample is available in the same cycle as the final BCLK rise.
    assign w_sample = {r_shift, serial_audio_in_data};

    if (DATA_WIDTH > AUDIO_DATA_WIDTH) begin : g_sign_extend
        assign w_sample_ext = {{(DATA_WIDTH - AUDIO_DATA_WIDTH){w_sample[AUDIO_DATA_WIDTH-1]}},
                               w_sample};
    end else begin : g_no_extend
        assign w_sample_ext = w_sample;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        w_shift_en    = 1'b0;
        w_last_bit    = 1'b0;
        w_frame_err   = 1'b0;
        if (!enable) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_next = c_ST_WAIT_SYNC;
                end
                c_ST_WAIT_SYNC: begin
                    // A falling edge of LRCK marks the start of a left frame.
                    if (w_lr_edge && !lr_clk) begin
                        w_start_frame = 1'b1;
                        w_state_next  = c_ST_FRAME_FIRST;
                    end
                end
`ifndef AUDIO_IN_LEFT_JUSTIFIED_EN
                c_ST_SKIP: begin
                    if (w_lr_edge) begin
                        w_frame_err  = 1'b1;
                        w_state_next = c_ST_WAIT_SYNC;
                    end else if (w_bclk_rise) begin
                        w_state_next = c_ST_SHIFT;
                    end
                end
`endif
                c_ST_SHIFT: begin
                    // If an LRCK edge and a BCLK rise occur together, the
                    // edge takes priority. This means the frame is short.
                    if (w_lr_edge) begin
                        w_frame_err  = 1'b1;
                        w_state_next = c_ST_WAIT_SYNC;
                    end else if (w_bclk_rise) begin
                        w_shift_en = 1'b1;
                        if (r_cnt == c_LAST_CNT) begin
                            w_last_bit   = 1'b1;
                            w_state_next = c_ST_HOLD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    // Any BCLK rise that arrives together with the edge is
                    // ignored here on purpose.
                    if (w_lr_edge) begin
                        w_start_frame = 1'b1;
                        w_state_next  = c_ST_FRAME_FIRST;
                    end
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write strobe. The full flag is checked in the strobe cycle itself.
    // ------------------------------------------------------------------
    assign w_target_full = r_channel ? right_fifo_is_full : left_fifo_is_full;
    assign w_left_we     = r_wr_pulse & enable & ~r_channel & ~left_fifo_is_full;
    assign w_right_we    = r_wr_pulse & enable &  r_channel & ~right_fifo_is_full;
    assign w_drop        = r_wr_pulse & enable & w_target_full;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_clk_q      <= 1'b0;
            r_lr_clk_q       <= 1'b0;
            r_channel        <= 1'b0;
            r_shift          <= '0;
            r_cnt            <= '0;
            r_wr_pulse       <= 1'b0;
            r_write_data     <= '0;
            r_overflow_count <= 8'd0;
            r_sync_locked    <= 1'b0;
        end else begin
            r_bit_clk_q <= bit_clk;
            r_lr_clk_q  <= lr_clk;
            r_wr_pulse  <= w_last_bit;

            if (w_start_frame) begin
                r_channel <= lr_clk;
            end

            if (w_shift_en) begin
                r_shift <= w_sample[AUDIO_DATA_WIDTH-2:0];
            end

            // The counter restarts for every new frame. Because of this,
            // any partial sample left behind by an error or by disable is
            // overwritten and never reaches the output.
            if (!enable || w_start_frame || w_frame_err || w_last_bit) begin
                r_cnt <= '0;
            end else if (w_shift_en) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_last_bit) begin
                r_write_data <= w_sample_ext;
            end

            if (w_drop && (r_overflow_count != 8'hFF)) begin
                r_overflow_count <= r_overflow_count + 8'd1;
            end

            if (!enable || w_frame_err) begin
                r_sync_locked <= 1'b0;
            end else if (w_left_we || w_right_we) begin
                r_sync_locked <= 1'b1;
            end
        end
    end

    assign left_write_en  = w_left_we;
    assign right_write_en = w_right_we;
    assign write_data     = r_write_data;
    assign overflow_count = r_overflow_count;
    assign sync_locked    = r_sync_locked;

endmodule
`default_nettype wire

// File: tb/tb_audio_in_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_in_deserializer
// Purpose  : Directed self-checking bench for audio_in_deserializer. It
//            drives I2S frames (or left-justified frames) and checks the
//            FIFO write strobes, the sample data, the overflow count and
//            the lock status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_in_deserializer;

    localparam int c_DW   = 32;
    localparam int c_AW   = 24;
    localparam int c_HALF = 26;   // BCLK slots per LRCK half-period
`ifdef AUDIO_IN_LEFT_JUSTIFIED_EN
    localparam int c_OFS  = 0;
`else
    localparam int c_OFS  = 1;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            bit_clk;
    logic            lr_clk;
    logic            serial_audio_in_data;
    logic            enable;
    logic            left_fifo_is_full;
    logic            right_fifo_is_full;
    wire             left_write_en;
    wire             right_write_en;
    wire [c_DW-1:0]  write_data;
    wire [7:0]       overflow_count;
    wire             sync_locked;

    int tests = 0;
    int fails = 0;

    // Write monitor
    int          left_cnt   = 0;
    int          right_cnt  = 0;
    int          both_cnt   = 0;
    int          multi_cnt  = 0;
    logic [31:0] last_left  = 32'h0;
    logic [31:0] last_right = 32'h0;
    logic        prev_left  = 1'b0;
    logic        prev_right = 1'b0;

    audio_in_deserializer #(
        .DATA_WIDTH       (c_DW),
        .AUDIO_DATA_WIDTH (c_AW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .bit_clk              (bit_clk),
        .lr_clk               (lr_clk),
        .serial_audio_in_data (serial_audio_in_data),
        .enable               (enable),
        .left_fifo_is_full    (left_fifo_is_full),
        .right_fifo_is_full   (right_fifo_is_full),
        .left_write_en        (left_write_en),
        .right_write_en       (right_write_en),
        .write_data           (write_data),
        .overflow_count       (overflow_count),
        .sync_locked          (sync_locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (left_write_en) begin
            left_cnt  <= left_cnt + 1;
            last_left <= write_data;
        end
        if (right_write_en) begin
            right_cnt  <= right_cnt + 1;
            last_right <= write_data;
        end
        if (left_write_en && right_write_en)
            both_cnt <= both_cnt + 1;
        if ((left_write_en && prev_left) || (right_write_en && prev_right))
            multi_cnt <= multi_cnt + 1;
        prev_left  <= left_write_en;
        prev_right <= right_write_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each slot is one BCLK period of 4 clk cycles: 2 cycles low, then
    // 2 cycles high. LRCK and the data bit change together with the falling
    // edge of BCLK.
    task automatic send_slots(input logic lr, input logic [23:0] s,
                              input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int k;
            k = i - c_OFS;
            @(posedge clk); #1;
            bit_clk = 1'b0;
            lr_clk  = lr;
            serial_audio_in_data = (k >= 0 && k < c_AW) ? s[c_AW-1-k] : 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            bit_clk = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slots(1'b0, l, 0, c_HALF - 1);
        send_slots(1'b1, r, 0, c_HALF - 1);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        bit_clk = 1'b0;
        lr_clk = 1'b1;
        serial_audio_in_data = 1'b0;
        left_fifo_is_full = 1'b0;
        right_fifo_is_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lwe", {31'b0, left_write_en}, 32'h0);
        check("rst_rwe", {31'b0, right_write_en}, 32'h0);
        check("rst_data", write_data, 32'h0);
        check("rst_ovf", {24'b0, overflow_count}, 32'h0);
        check("rst_lock", {31'b0, sync_locked}, 32'h0);

        // Basic stereo capture
        @(posedge clk); #1;
        reset = 1'b0;
        enable = 1'b1;
        send_slots(1'b1, 24'h0, 0, c_HALF - 1);
        send_frame(24'h123456, 24'h800001);
        check("basic_lcnt", left_cnt, 1);
        check("basic_ldata", last_left, 32'h00123456);
        check("basic_rcnt", right_cnt, 1);
        check("basic_rdata", last_right, 32'hFF800001);
        check("basic_hold", write_data, 32'hFF800001);
        check("basic_lock", {31'b0, sync_locked}, 32'h1);
        check("basic_ovf", {24'b0, overflow_count}, 32'h0);

        // Left FIFO is full for three frames
        left_fifo_is_full = 1'b1;
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        send_frame(24'h555555, 24'h666666);
        left_fifo_is_full = 1'b0;
        check("lfull_lcnt", left_cnt, 1);
        check("lfull_rcnt", right_cnt, 4);
        check("lfull_rdata", last_right, 32'h00666666);
        check("lfull_ovf", {24'b0, overflow_count}, 32'h3);

        // LRCK toggles after 10 bits of a left frame
        send_slots(1'b0, 24'hABCDEF, 0, 10);
        send_slots(1'b1, 24'h123123, 0, c_HALF - 1);
        check("ferr_lock", {31'b0, sync_locked}, 32'h0);
        check("ferr_lcnt", left_cnt, 1);
        check("ferr_rcnt", right_cnt, 4);
        send_frame(24'h0F0F0F, 24'h7FFFFF);
        check("recov_lcnt", left_cnt, 2);
        check("recov_ldata", last_left, 32'h000F0F0F);
        check("recov_rcnt", right_cnt, 5);
        check("recov_rdata", last_right, 32'h007FFFFF);
        check("recov_lock", {31'b0, sync_locked}, 32'h1);

        // Reset is asserted during bit 12 of a left frame
        send_slots(1'b0, 24'h555555, 0, 12);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_lwe", {31'b0, left_write_en}, 32'h0);
        check("mrst_rwe", {31'b0, right_write_en}, 32'h0);
        check("mrst_data", write_data, 32'h0);
        check("mrst_ovf", {24'b0, overflow_count}, 32'h0);
        check("mrst_lock", {31'b0, sync_locked}, 32'h0);
        reset = 1'b0;
        send_slots(1'b0, 24'h555555, 13, c_HALF - 1);
        send_slots(1'b1, 24'h777777, 0, c_HALF - 1);
        check("mrst_nolcnt", left_cnt, 2);
        check("mrst_norcnt", right_cnt, 5);
        send_frame(24'h654321, 24'h000010);
        check("mrst_lcnt", left_cnt, 3);
        check("mrst_ldata", last_left, 32'h00654321);
        check("mrst_rcnt", right_cnt, 6);
        check("mrst_rdata", last_right, 32'h00000010);

        // Both FIFOs are full. The overflow count saturates at 255.
        left_fifo_is_full = 1'b1;
        right_fifo_is_full = 1'b1;
        repeat (127) send_frame(24'h000001, 24'h000002);
        check("sat_254", {24'b0, overflow_count}, 32'd254);
        repeat (173) send_frame(24'h000001, 24'h000002);
        check("sat_255", {24'b0, overflow_count}, 32'd255);
        check("sat_lcnt", left_cnt, 3);
        check("sat_rcnt", right_cnt, 6);

        check("never_both", both_cnt, 0);
        check("one_cycle", multi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
